// File: rtl/pong_pkg.sv
// pong_pkg: state encoding and datapath width constants shared by the Pong game controller
package pong_pkg;
  localparam int BALLX_W = 11;
  localparam int BALLY_W = 9;
  localparam int SCORE_W = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    OVER  = 3'd3
  } state_t;
endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: controller <-> ball/paddle datapath signals.
// master (controller): takes frame_tick, start_btn, paddle_hit, ball_y; drives ball_run, ball_load,
// ball_x0, ball_y0, score, lives, game_over, state. slave is the datapath/bench view.
interface pong_game_ctrl_if import pong_pkg::*; ();
  logic               frame_tick;
  logic               start_btn;
  logic               paddle_hit;
  logic [BALLY_W-1:0] ball_y;
  logic               ball_run;
  logic               ball_load;
  logic [BALLX_W-1:0] ball_x0;
  logic [BALLY_W-1:0] ball_y0;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               game_over;
  logic [2:0]         state;
  modport master (
    input  frame_tick, start_btn, paddle_hit, ball_y,
    output ball_run, ball_load, ball_x0, ball_y0, score, lives, game_over, state
  );
  modport slave (
    output frame_tick, start_btn, paddle_hit, ball_y,
    input  ball_run, ball_load, ball_x0, ball_y0, score, lives, game_over, state
  );
endinterface

// File: rtl/pong_btn_sync.sv
// pong_btn_sync: 2-FF synchroniser plus rising-edge detector for the start button.
// clk/rst: clock, async active-high reset; btn: raw async level; pulse: one cycle per press.
module pong_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[1:0], btn};
  assign pulse = sync[1] & ~sync[2];
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game-flow FSM (idle, serve delay, play, over) with score and lives.
// clk/rst: clock, async active-high reset; bus: pong_game_ctrl_if.master (see interface).
// PONG_ATTRACT_EN: when defined the ball runs in IDLE as an attract demo.
module pong_game_ctrl import pong_pkg::*; #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int BALL_X0      = 320,
  parameter int BALL_Y0      = 200,
  parameter int MISS_Y       = 460
) (
  input  logic               clk,
  input  logic               rst,
  pong_game_ctrl_if.master   bus
);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]         SERVE_INIT = 8'(SERVE_FRAMES);
  localparam logic [BALLY_W-1:0] MISS_LIM   = BALLY_W'(MISS_Y);
`ifdef PONG_ATTRACT_EN
  localparam logic ATTRACT = 1'b1;
`else
  localparam logic ATTRACT = 1'b0;
`endif
  state_t             st, st_d;
  logic [7:0]         cnt, cnt_d;
  logic [SCORE_W-1:0] score, score_d;
  logic [2:0]         lives, lives_d;
  logic               load, load_d, run, over, start_p, miss;
  pong_btn_sync u_sync (.clk(clk), .rst(rst), .btn(bus.start_btn), .pulse(start_p));
  always_comb begin
    st_d    = st;
    cnt_d   = cnt;
    score_d = score;
    lives_d = lives;
    load_d  = 1'b0;
    miss    = bus.frame_tick && bus.ball_y >= MISS_LIM;
    case (st)
      IDLE: begin
        score_d = '0;
        lives_d = LIVES_INIT;
        if (start_p) begin
          st_d   = SERVE;
          load_d = 1'b1;
          cnt_d  = SERVE_INIT;
        end
      end
      SERVE: if (bus.frame_tick) begin
        cnt_d = cnt - 1'b1;
        st_d  = cnt == 8'd1 ? PLAY : SERVE;
      end
      PLAY: begin
        // a miss on the same cycle as a hit takes priority and the hit is dropped
        if (miss) begin
          lives_d = lives - 1'b1;
          if (lives == 3'd1) st_d = OVER;
          else begin
            st_d   = SERVE;
            load_d = 1'b1;
            cnt_d  = SERVE_INIT;
          end
        end else if (bus.paddle_hit && score != '1) score_d = score + 1'b1;
      end
      OVER: if (start_p) begin
        score_d = '0;
        lives_d = LIVES_INIT;
        st_d    = SERVE;
        load_d  = 1'b1;
        cnt_d   = SERVE_INIT;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st    <= IDLE;
      cnt   <= '0;
      score <= '0;
      lives <= LIVES_INIT;
      load  <= 1'b0;
      run   <= ATTRACT;
      over  <= 1'b0;
    end else begin
      st    <= st_d;
      cnt   <= cnt_d;
      score <= score_d;
      lives <= lives_d;
      load  <= load_d;
      run   <= st_d == PLAY || (ATTRACT && st_d == IDLE);
      over  <= st_d == OVER;
    end
  assign bus.ball_run  = run;
  assign bus.ball_load = load;
  assign bus.ball_x0   = BALLX_W'(BALL_X0);
  assign bus.ball_y0   = BALLY_W'(BALL_Y0);
  assign bus.score     = score;
  assign bus.lives     = lives;
  assign bus.game_over = over;
  assign bus.state     = st;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scenarios plus randomized play against a rule-level reference model
module tb_pong_game_ctrl;
  localparam int LIVES = 3;
  localparam int SF    = 4;
  localparam int MISSY = 460;
`ifdef PONG_ATTRACT_EN
  localparam bit ATTR = 1'b1;
`else
  localparam bit ATTR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  pong_game_ctrl_if bus ();
  pong_game_ctrl #(.LIVES(LIVES), .SERVE_FRAMES(SF), .BALL_X0(320), .BALL_Y0(200), .MISS_Y(MISSY))
    dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  logic [16:0] obs;
  assign obs = {bus.state, bus.score, bus.lives, bus.ball_load, bus.ball_run, bus.game_over};
  // reference model: game mode 0 idle, 1 serve, 2 play, 3 over
  int m_mode, m_left, m_score, m_lives;
  bit m_load;
  bit [3:0] hist;
  function automatic logic [16:0] expv();
    bit run = m_mode == 2 || (ATTR && m_mode == 0);
    return {3'(m_mode), 8'(m_score), 3'(m_lives), m_load, run, m_mode == 3};
  endfunction
  function automatic void model_reset();
    m_mode = 0; m_left = 0; m_score = 0; m_lives = LIVES; m_load = 0; hist = '0;
  endfunction
  function automatic void new_serve();
    m_mode = 1; m_left = SF; m_load = 1;
  endfunction
  function automatic void model_step();
    bit press;
    if (rst) begin model_reset(); return; end
    hist = {hist[2:0], bus.start_btn};
    press = hist[2] && !hist[3];
    m_load = 0;
    if (m_mode == 0 || m_mode == 3) begin
      if (m_mode == 0) begin m_score = 0; m_lives = LIVES; end
      if (press) begin m_score = 0; m_lives = LIVES; new_serve(); end
    end else if (m_mode == 1) begin
      if (bus.frame_tick) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 2;
      end
    end else if (bus.frame_tick && int'(bus.ball_y) >= MISSY) begin
      m_lives = m_lives - 1;
      if (m_lives == 0) m_mode = 3;
      else new_serve();
    end else if (bus.paddle_hit) m_score = m_score + 1 > 255 ? 255 : m_score + 1;
  endfunction
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic serve_ticks();
    for (int j = 1; j <= SF; j++) begin
      bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
      checks++;
      if (bus.ball_run !== (j == SF)) begin
        errors++; $display("FAIL serve_run tick %0d: got %b want %b", j, bus.ball_run, j == SF);
      end
      step(); step();
    end
  endtask
  task automatic test_reset();
    bus.frame_tick = 0; bus.start_btn = 0; bus.paddle_hit = 0; bus.ball_y = 9'd100;
    model_reset();
    #23;
    checks++;
    if (obs !== {3'd0, 8'd0, 3'd3, 1'b0, ATTR, 1'b0}) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, {3'd0, 8'd0, 3'd3, 1'b0, ATTR, 1'b0});
    end
    checks++;
    if (bus.ball_x0 !== 11'd320 || bus.ball_y0 !== 9'd200) begin
      errors++; $display("FAIL reset_consts: got %0d/%0d want 320/200", bus.ball_x0, bus.ball_y0);
    end
    step(); rst = 1'b0; step(); step();
  endtask
  task automatic test_start();
    int loads = 0, first = -1;
    bus.start_btn = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bus.ball_load) begin loads++; if (first < 0) first = k; end
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL start_model cyc %0d: got %h want %h", k, obs, expv()); end
    end
    checks++;
    if (loads != 1 || first != 3) begin
      errors++; $display("FAIL start_load: got %0d pulses at %0d want 1 at 3", loads, first);
    end
    checks++;
    if (bus.state !== 3'd1) begin errors++; $display("FAIL start_state: got %0d want 1", bus.state); end
    bus.start_btn = 1'b0;
    step();
  endtask
  task automatic test_serve();
    serve_ticks();
    checks++;
    if (bus.state !== 3'd2 || bus.ball_run !== 1'b1) begin
      errors++; $display("FAIL serve_play: got state %0d run %b want 2 1", bus.state, bus.ball_run);
    end
  endtask
  task automatic test_score_sat();
    bus.paddle_hit = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      checks++;
      if (bus.score !== 8'(k > 255 ? 255 : k)) begin
        errors++; $display("FAIL score_sat hit %0d: got %0d want %0d", k, bus.score, k > 255 ? 255 : k);
      end
    end
    bus.paddle_hit = 1'b0;
  endtask
  task automatic test_miss();
    for (int r = 0; r < 3; r++) begin
      bus.ball_y = 9'd470; bus.frame_tick = 1'b1; step();
      bus.ball_y = 9'd100; bus.frame_tick = 1'b0;
      checks++;
      if (bus.lives !== 3'(2 - r)) begin errors++; $display("FAIL miss_lives %0d: got %0d want %0d", r, bus.lives, 2 - r); end
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL miss_model %0d: got %h want %h", r, obs, expv()); end
      if (r < 2) begin
        checks++;
        if (bus.state !== 3'd1 || bus.ball_load !== 1'b1 || bus.ball_run !== 1'b0) begin
          errors++; $display("FAIL miss_serve %0d: got st %0d load %b run %b want 1 1 0", r, bus.state, bus.ball_load, bus.ball_run);
        end
        step();
        checks++;
        if (bus.ball_load !== 1'b0) begin errors++; $display("FAIL miss_load_len %0d: got %b want 0", r, bus.ball_load); end
        serve_ticks();
      end
    end
    repeat (5) step();
    checks++;
    if (bus.state !== 3'd3 || bus.game_over !== 1'b1 || bus.lives !== 3'd0 || bus.score !== 8'd255) begin
      errors++; $display("FAIL over: got st %0d go %b lives %0d score %0d want 3 1 0 255", bus.state, bus.game_over, bus.lives, bus.score);
    end
  endtask
  task automatic test_restart_and_hit_miss();
    bus.start_btn = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.state !== 3'd1 || bus.score !== 8'd0 || bus.lives !== 3'd3 || bus.ball_load !== 1'b1) begin
      errors++; $display("FAIL restart: got st %0d score %0d lives %0d load %b want 1 0 3 1", bus.state, bus.score, bus.lives, bus.ball_load);
    end
    bus.start_btn = 1'b0;
    serve_ticks();
    bus.paddle_hit = 1'b1; repeat (5) step();
    bus.ball_y = 9'd470; bus.frame_tick = 1'b1; step();
    bus.paddle_hit = 1'b0; bus.frame_tick = 1'b0; bus.ball_y = 9'd100;
    checks++;
    if (bus.score !== 8'd5 || bus.lives !== 3'd2) begin
      errors++; $display("FAIL hit_miss_same: got score %0d lives %0d want 5 2", bus.score, bus.lives);
    end
  endtask
  task automatic test_mid_reset();
    serve_ticks();
    bus.paddle_hit = 1'b1; step(); step(); bus.paddle_hit = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== {3'd0, 8'd0, 3'd3, 1'b0, ATTR, 1'b0}) begin
      errors++; $display("FAIL mid_reset: got %h want %h", obs, {3'd0, 8'd0, 3'd3, 1'b0, ATTR, 1'b0});
    end
    step(); step(); rst = 1'b0;
  endtask
  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) bus.start_btn = ~bus.start_btn;
      bus.frame_tick = $urandom_range(0, 3) == 0;
      bus.paddle_hit = $urandom_range(0, 2) == 0;
      bus.ball_y     = 9'($urandom_range(0, 511));
      rst            = $urandom_range(0, 499) == 0;
      step();
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random cyc %0d: got %h want %h", k, obs, expv()); end
    end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_start();
    test_serve();
    test_score_sat();
    test_miss();
    test_restart_and_hit_miss();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
